// File: rtl/ex_if.sv
// Bus between the load pipeline register and the execute/write-back stage.
// The master side is the upstream stage; the slave side is ex_stage.
// Optional macro EX_FWD_EN adds the forwarding outputs fwd_valid/fwd_adr/fwd_data.
interface ex_if #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned ADDR_W = 6
);
   logic              halted_in;
   logic [ADDR_W-1:0] write_adr_in;
   logic [1:0]        alu_inst_in;
   logic [DATA_W-1:0] data_in_1;
   logic [DATA_W-1:0] data_in_2;
   logic              data_mem_write_in;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_adr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              freeze;
   logic              core_halted;
`ifdef EX_FWD_EN
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_adr;
   logic [DATA_W-1:0] fwd_data;
`endif

   // Upstream view: drives the instruction, observes write-back and stall
   modport master (
      output halted_in, write_adr_in, alu_inst_in, data_in_1, data_in_2, data_mem_write_in,
      input  mem_wr_en, mem_wr_adr, mem_wr_data, freeze, core_halted
`ifdef EX_FWD_EN
      , input fwd_valid, fwd_adr, fwd_data
`endif
   );

   // Stage view: consumes the instruction, produces write-back and stall
   modport slave (
      input  halted_in, write_adr_in, alu_inst_in, data_in_1, data_in_2, data_mem_write_in,
      output mem_wr_en, mem_wr_adr, mem_wr_data, freeze, core_halted
`ifdef EX_FWD_EN
      , output fwd_valid, fwd_adr, fwd_data
`endif
   );
endinterface

// File: rtl/ex_stage.sv
// Execute/write-back stage: ALU (ADD/SUB/NAND single cycle, MUL iterative
// shift-add), one-cycle data-memory write, pipeline freeze and sticky halt.
// Optional macro EX_FWD_EN exposes the write-back as forwarding outputs.
module ex_stage #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned ADDR_W = 6
) (
   input  logic clk,
   input  logic rst,
   ex_if.slave  bus
);
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HALT = 2'd2
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_adr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_freeze;
   logic              r_halted;
   logic              w_wr_en_nxt;
   logic [ADDR_W-1:0] w_wr_adr_nxt;
   logic [DATA_W-1:0] w_wr_data_nxt;
   logic              w_freeze_nxt;
   logic              w_halted_nxt;

   // Multiplier state: shifted multiplicand, shifted multiplier, running sum
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_acc;
   logic [ADDR_W-1:0] r_mul_adr;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] w_mcand_nxt;
   logic [DATA_W-1:0] w_mplier_nxt;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [ADDR_W-1:0] w_mul_adr_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   logic [DATA_W-1:0] w_alu_res;
   logic [DATA_W-1:0] w_acc_sum;

   // Single-cycle ALU result; carry/borrow fall off the top bit
   always_comb begin
      w_alu_res = '0;
      case (bus.alu_inst_in)
         OP_ADD:  w_alu_res = bus.data_in_1 + bus.data_in_2;
         OP_SUB:  w_alu_res = bus.data_in_1 - bus.data_in_2;
         OP_NAND: w_alu_res = ~(bus.data_in_1 & bus.data_in_2);
         default: w_alu_res = '0;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_wr_en_nxt   = 1'b0;
      w_wr_adr_nxt  = r_wr_adr;
      w_wr_data_nxt = r_wr_data;
      w_freeze_nxt  = 1'b0;
      w_halted_nxt  = r_halted;
      w_mcand_nxt   = r_mcand;
      w_mplier_nxt  = r_mplier;
      w_acc_nxt     = r_acc;
      w_mul_adr_nxt = r_mul_adr;
      w_cnt_nxt     = r_cnt;

      unique case (r_state)
         S_IDLE: begin
            if (bus.halted_in) begin
               // Halt wins over a simultaneous live write
               w_state_nxt  = S_HALT;
               w_halted_nxt = 1'b1;
            end else if (bus.data_mem_write_in) begin
               if (bus.alu_inst_in == OP_MUL) begin
                  w_mcand_nxt   = bus.data_in_1;
                  w_mplier_nxt  = bus.data_in_2;
                  w_mul_adr_nxt = bus.write_adr_in;
                  w_acc_nxt     = '0;
                  w_cnt_nxt     = '0;
                  w_freeze_nxt  = 1'b1;
                  w_state_nxt   = S_MUL;
               end else begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_adr_nxt  = bus.write_adr_in;
                  w_wr_data_nxt = w_alu_res;
               end
            end
         end
         S_MUL: begin
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_acc_nxt    = w_acc_sum;
            w_cnt_nxt    = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
               // Last bit: write the product and release the pipeline together
               w_wr_en_nxt   = 1'b1;
               w_wr_adr_nxt  = r_mul_adr;
               w_wr_data_nxt = w_acc_sum;
               w_state_nxt   = S_IDLE;
            end else begin
               w_freeze_nxt = 1'b1;
            end
         end
         S_HALT: begin
            w_halted_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, output and multiplier registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wr_en   <= 1'b0;
         r_wr_adr  <= '0;
         r_wr_data <= '0;
         r_freeze  <= 1'b0;
         r_halted  <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_mul_adr <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_adr  <= w_wr_adr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_freeze  <= w_freeze_nxt;
         r_halted  <= w_halted_nxt;
         r_mcand   <= w_mcand_nxt;
         r_mplier  <= w_mplier_nxt;
         r_acc     <= w_acc_nxt;
         r_mul_adr <= w_mul_adr_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign bus.mem_wr_en   = r_wr_en;
   assign bus.mem_wr_adr  = r_wr_adr;
   assign bus.mem_wr_data = r_wr_data;
   assign bus.freeze      = r_freeze;
   assign bus.core_halted = r_halted;

`ifdef EX_FWD_EN
   // Forwarding copy of the write-back, taken straight from the write registers
   assign bus.fwd_valid = r_wr_en;
   assign bus.fwd_adr   = r_wr_adr;
   assign bus.fwd_data  = r_wr_data;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: per-cycle compare against a behavioural
// model plus directed literal checks. Honours EX_FWD_EN if defined.
module tb_ex_stage;
   localparam int unsigned DATA_W = 6;
   localparam int unsigned ADDR_W = 6;
   localparam int MASK = (1 << DATA_W) - 1;

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, NAND = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      total++;
      if (act !== 32'(exp)) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of one instruction
   function automatic int model_alu(input logic [1:0] op, input int a, input int b);
      case (op)
         ADD:     return (a + b) & MASK;
         SUB:     return (a - b) & MASK;
         MUL:     return (a * b) & MASK;
         default: return (~(a & b)) & MASK;
      endcase
   endfunction

   // Behavioural model: a multiply keeps the stage busy for DATA_W cycles and
   // then writes its product; everything else writes one cycle later.
   int m_busy, m_adr, m_data, m_padr, m_pdata;
   bit m_en, m_halt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_en <= 1'b0; m_halt <= 1'b0;
         m_adr <= 0; m_data <= 0; m_padr <= 0; m_pdata <= 0;
      end else if (m_halt) begin
         m_en <= 1'b0;
      end else if (m_busy != 0) begin
         m_busy <= m_busy - 1;
         m_en   <= (m_busy == 1);
         if (m_busy == 1) begin
            m_adr  <= m_padr;
            m_data <= m_pdata;
         end
      end else if (bus.halted_in) begin
         m_halt <= 1'b1;
         m_en   <= 1'b0;
      end else if (!bus.data_mem_write_in) begin
         m_en <= 1'b0;
      end else if (bus.alu_inst_in == MUL) begin
         m_busy  <= DATA_W;
         m_en    <= 1'b0;
         m_padr  <= int'(bus.write_adr_in);
         m_pdata <= model_alu(MUL, int'(bus.data_in_1), int'(bus.data_in_2));
      end else begin
         m_en   <= 1'b1;
         m_adr  <= int'(bus.write_adr_in);
         m_data <= model_alu(bus.alu_inst_in, int'(bus.data_in_1), int'(bus.data_in_2));
      end
   end

   // Per-cycle compare on the falling edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cyc_wr_en", 32'(bus.mem_wr_en), int'(m_en));
         chk("cyc_freeze", 32'(bus.freeze), int'(m_busy != 0));
         chk("cyc_halted", 32'(bus.core_halted), int'(m_halt));
         if (m_en) begin
            chk("cyc_wr_adr", 32'(bus.mem_wr_adr), m_adr);
            chk("cyc_wr_data", 32'(bus.mem_wr_data), m_data);
         end
`ifdef EX_FWD_EN
         chk("cyc_fwd_valid", 32'(bus.fwd_valid), int'(bus.mem_wr_en));
         chk("cyc_fwd_adr", 32'(bus.fwd_adr), int'(bus.mem_wr_adr));
         chk("cyc_fwd_data", 32'(bus.fwd_data), int'(bus.mem_wr_data));
`endif
      end
   end

   task automatic drive(input bit h, input bit w, input logic [1:0] op,
                        input int a, input int b, input int adr);
      bus.halted_in         = h;
      bus.data_mem_write_in = w;
      bus.alu_inst_in       = op;
      bus.data_in_1         = DATA_W'(a);
      bus.data_in_2         = DATA_W'(b);
      bus.write_adr_in      = ADDR_W'(adr);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles with freeze high; returns on the first cycle it is low
   task automatic wait_mul(input string name);
      int n;
      n = 0;
      while (bus.freeze === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      chk(name, 32'(n), DATA_W);
   endtask

   typedef struct {
      logic [1:0] op;
      int a;
      int b;
      int exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{ADD, 63, 1, 0};
      vecs[1] = '{SUB, 0, 1, 63};
      vecs[2] = '{NAND, 0, 0, 63};
      vecs[3] = '{MUL, 63, 63, 1};
      vecs[4] = '{ADD, 32, 32, 0};

      drive(0, 0, ADD, 0, 0, 0);
      #2;
      chk("rst_wr_en", 32'(bus.mem_wr_en), 0);
      chk("rst_freeze", 32'(bus.freeze), 0);
      chk("rst_halted", 32'(bus.core_halted), 0);
      chk("rst_wr_adr", 32'(bus.mem_wr_adr), 0);
      chk("rst_wr_data", 32'(bus.mem_wr_data), 0);
      @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;
      tick();

      // ADD with wrap
      drive(0, 1, ADD, 25, 50, 3);
      tick();
      chk("add_en", 32'(bus.mem_wr_en), 1);
      chk("add_adr", 32'(bus.mem_wr_adr), 3);
      chk("add_data", 32'(bus.mem_wr_data), 11);
      chk("model_add_data", 32'(m_data), 11);
      drive(0, 0, ADD, 25, 50, 3);
      tick();
      chk("add_bubble_en", 32'(bus.mem_wr_en), 0);
      chk("bubble_hold_data", 32'(bus.mem_wr_data), 11);

      // SUB then NAND back to back
      drive(0, 1, SUB, 5, 9, 4);
      tick();
      chk("sub_en", 32'(bus.mem_wr_en), 1);
      chk("sub_data", 32'(bus.mem_wr_data), 60);
      drive(0, 1, NAND, 63, 15, 5);
      tick();
      chk("nand_en", 32'(bus.mem_wr_en), 1);
      chk("nand_data", 32'(bus.mem_wr_data), 48);
      drive(0, 0, ADD, 0, 0, 0);
      tick();

      // MUL with an ADD held upstream during freeze
      drive(0, 1, MUL, 7, 9, 10);
      tick();
      drive(0, 1, ADD, 1, 1, 11);
      wait_mul("mul_freeze_len");
      chk("mul_en", 32'(bus.mem_wr_en), 1);
      chk("mul_data", 32'(bus.mem_wr_data), 63);
      chk("mul_adr", 32'(bus.mem_wr_adr), 10);
      tick();
      chk("held_add_en", 32'(bus.mem_wr_en), 1);
      chk("held_add_data", 32'(bus.mem_wr_data), 2);
      chk("held_add_adr", 32'(bus.mem_wr_adr), 11);
      drive(0, 0, ADD, 0, 0, 0);
      tick();
      chk("post_mul_en", 32'(bus.mem_wr_en), 0);

      // MUL overflow
      drive(0, 1, MUL, 9, 8, 12);
      tick();
      drive(0, 0, ADD, 0, 0, 0);
      wait_mul("mulov_freeze_len");
      chk("mulov_data", 32'(bus.mem_wr_data), 8);
      chk("mulov_en", 32'(bus.mem_wr_en), 1);
      tick();

      // Boundary vectors, single-cycle ops issued back to back
      foreach (vecs[i]) begin
         drive(0, 1, vecs[i].op, vecs[i].a, vecs[i].b, 40 + i);
         tick();
         if (vecs[i].op == MUL) begin
            drive(0, 0, ADD, 0, 0, 0);
            wait_mul("vec_mul_freeze_len");
         end
         chk("vec_en", 32'(bus.mem_wr_en), 1);
         chk("vec_data", 32'(bus.mem_wr_data), vecs[i].exp);
         chk("vec_adr", 32'(bus.mem_wr_adr), 40 + i);
      end
      drive(0, 0, ADD, 0, 0, 0);
      tick();

      // Reset in the middle of a multiply
      drive(0, 1, MUL, 5, 5, 20);
      tick();
      drive(0, 0, ADD, 0, 0, 0);
      tick();
      tick();
      tick();
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_freeze", 32'(bus.freeze), 0);
      chk("midrst_en", 32'(bus.mem_wr_en), 0);
      chk("midrst_halted", 32'(bus.core_halted), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, ADD, 2, 3, 21);
      tick();
      chk("postrst_en", 32'(bus.mem_wr_en), 1);
      chk("postrst_data", 32'(bus.mem_wr_data), 5);
      chk("postrst_adr", 32'(bus.mem_wr_adr), 21);

      // Halt has priority and is absorbing
      drive(1, 1, ADD, 1, 2, 30);
      tick();
      chk("halt_flag", 32'(bus.core_halted), 1);
      chk("halt_en", 32'(bus.mem_wr_en), 0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, (k == 2) ? MUL : ADD, k, k, 31 + k);
         tick();
         chk("halted_no_write", 32'(bus.mem_wr_en), 0);
         chk("halted_freeze", 32'(bus.freeze), 0);
         chk("halted_sticky", 32'(bus.core_halted), 1);
      end
      drive(0, 0, ADD, 0, 0, 0);
      #1;
      rst = 1'b1;
      #1;
      chk("halt_cleared", 32'(bus.core_halted), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute/write-back stage directly downstream of the load pipeline register.
- Consumes the registered operands, ALU opcode, destination address, write flag and halt flag.
- Computes the result and issues a one-cycle data-memory write.
- Owns the pipeline-wide freeze signal: asserts it while an iterative multiply occupies the stage, and raises a sticky core-halt when a halted instruction arrives.

Parameters:
- DATA_W, 6, operand/result width (unsigned)
- ADDR_W, 6, data-memory address width

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous active-high reset
- halted_in  input  1  halt flag from load stage
- write_adr_in  input  ADDR_W  destination address
- alu_inst_in  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 NAND
- data_in_1  input  DATA_W  operand A
- data_in_2  input  DATA_W  operand B
- data_mem_write_in  input  1  live instruction: result is written when 1; cycle is a bubble when 0
- mem_wr_en  output  1  data-memory write strobe
- mem_wr_adr  output  ADDR_W  write address
- mem_wr_data  output  DATA_W  write data
- freeze  output  1  stall for all upstream stages; registered
- core_halted  output  1  sticky halt indication

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; multiply registers and counter cleared. Reset mid-MUL aborts the multiply with no write.
- States: IDLE, MUL, HALT.
- IDLE, evaluated at every rising edge:
  - halted_in=1 -> HALT. core_halted<=1, mem_wr_en<=0. Halt has priority over a simultaneous data_mem_write_in=1.
  - data_mem_write_in=0 -> mem_wr_en<=0 (bubble). mem_wr_adr/mem_wr_data hold their previous values.
  - data_mem_write_in=1 with ADD/SUB/NAND:
    - mem_wr_en<=1, mem_wr_adr<=write_adr_in, mem_wr_data<=result. Latency 1 cycle.
    - ADD: (A+B) mod 2^DATA_W. SUB: (A-B) mod 2^DATA_W, two's-complement wrap. NAND: ~(A&B).
    - Carry/borrow is discarded.
  - data_mem_write_in=1 with MUL:
    - Latch A, B and address; product accumulator <=0; counter <=0.
    - freeze<=1, mem_wr_en<=0; state -> MUL.
- MUL:
  - Shift-add, one multiplier bit per cycle, LSB first. Counter increments each cycle.
  - Inputs are ignored; upstream holds the next instruction because freeze=1.
  - On the edge where counter reaches DATA_W-1:
    - mem_wr_en<=1; mem_wr_data<=(A*B) mod 2^DATA_W; mem_wr_adr<=latched address.
    - freeze<=0; state -> IDLE.
  - freeze is high for exactly DATA_W cycles. The write strobe coincides with the first cycle freeze is low.
  - The instruction held upstream is consumed at the next edge as a normal IDLE instruction.
- mem_wr_en is a single-cycle pulse per live instruction. It is never high two consecutive cycles for the same instruction.
- HALT: absorbing until rst. core_halted=1, mem_wr_en=0, freeze=0. All inputs ignored.
- Back-to-back single-cycle ops produce one write per cycle, with no bubbles inserted by this stage.

Optional Feature:
- Macro EX_FWD_EN.
- When defined, three outputs are added:
  - fwd_valid (1): equal to mem_wr_en
  - fwd_adr (ADDR_W): equal to mem_wr_adr
  - fwd_data (DATA_W): equal to mem_wr_data
  - All three reset to 0. The decode stage uses them to bypass a same-address memory read in the cycle the write lands.
- When undefined, these ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- ADD: A=25, B=50, adr=3, write=1 -> next cycle mem_wr_en=1, mem_wr_adr=3, mem_wr_data=11 (75 mod 64); following cycle, with write=0, mem_wr_en=0.
- SUB/NAND back-to-back: 5-9 then NAND(0x3F,0x0F) -> mem_wr_data=60, then 0x30, on consecutive cycles with mem_wr_en held 1 for 2 cycles.
- MUL: A=7, B=9, adr=10 -> freeze=1 for exactly 6 cycles; then mem_wr_en=1, mem_wr_data=63, adr=10. A held ADD 1+1 behind it is written (2) on the next cycle.
- MUL overflow: A=9, B=8 -> mem_wr_data=8 (72 mod 64).
- Halt: halted_in=1 together with write=1 -> next cycle core_halted=1, mem_wr_en=0. Later inputs produce no writes until rst.
- Reset mid-MUL: assert rst after 3 MUL cycles -> freeze, mem_wr_en and core_halted go 0 immediately (async). After release, an ADD 2+3 writes 5 normally. With EX_FWD_EN, the fwd_* outputs mirror the mem_wr_* outputs in every scenario.
